reg_writeback_arb: RTL and testbench
====================================

# reg_writeback_arb

Writeback arbiter directly upstream of the register file write port. Merges the single-cycle pipeline result stream with results from the multi-cycle multiply/divide unit (MDU), buffers MDU results in a small FIFO, and drives registered `rd`/`data_write`/`write_en` to the register file. Writes to x0 are suppressed. A per-register pending mask is exported for hazard detection.

## Interface
- `REG_DATA_WIDTH_POW`, 6, data width is 1<<POW (64 bits)
- `REG_MEM_DEPTH_POW`, 5, register index width (32 registers)
- `FIFO_DEPTH`, 2, MDU result buffer entries (≥1)
- `STARVE_LIMIT`, 4, cycles a FIFO head may wait before forcing a pipeline stall (≥1)

- `clk_in`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `pipe_valid`  in  1  pipeline result present this cycle
- `pipe_rd`  in  REG_MEM_DEPTH_POW  pipeline destination register
- `pipe_data`  in  REG_DATA_WIDTH  pipeline result
- `mdu_valid`  in  1  MDU result offered
- `mdu_rd`  in  REG_MEM_DEPTH_POW  MDU destination register
- `mdu_data`  in  REG_DATA_WIDTH  MDU result
- `mdu_ready`  out  1  FIFO can accept; transfer when `mdu_valid && mdu_ready`
- `pipe_stall_out`  out  1  upstream must hold `pipe_valid` low this cycle
- `rd_out`  out  REG_MEM_DEPTH_POW  to register file `rd_in`
- `data_write_out`  out  REG_DATA_WIDTH  to register file `data_write`
- `write_en_out`  out  1  to register file `write_en`
- `pending_mask_out`  out  1<<REG_MEM_DEPTH_POW  bit i set if a write to xi is queued or on the output stage

## Operation
- FIFO: FIFO_DEPTH entries of {rd, data}, count register, head/tail pointers wrapping modulo FIFO_DEPTH.
- `mdu_ready` = (count < FIFO_DEPTH), from registered count only; no same-cycle pop credit.
- MDU accept with `mdu_rd == 0`: handshake completes, entry discarded, not enqueued.
- Output-stage selection each cycle, priority order:
  1. `pipe_stall_out` high and FIFO non-empty → pop head.
  2. `pipe_valid && pipe_rd != 0` → pipeline result.
  3. FIFO non-empty → pop head.
  4. Otherwise `write_en_out` ← 0; `rd_out`/`data_write_out` hold.
- `pipe_valid` with `pipe_rd == 0` is consumed as a no-op; the FIFO may drain that cycle.
- Starvation counter: increments each cycle the FIFO is non-empty and the head is not popped; clears on pop or when the FIFO is empty. `pipe_stall_out` = (counter ≥ STARVE_LIMIT); it comes from registered state only.
- Push and pop in the same cycle are allowed: count unchanged and pointers both advance. A push into a full FIFO cannot occur because `mdu_ready` is low.
- `pending_mask_out`: OR of one-hot(rd) over valid FIFO entries, plus one-hot(`rd_out`) when `write_en_out` is high. Bit 0 is never set.
- No WAW reordering checks. Issue logic uses `pending_mask_out` to keep pipeline writes from overtaking queued MDU writes to the same rd.

## Timing
- Reset values: `write_en_out`=0, `rd_out`=0, `data_write_out`=0, count=0, pointers=0, starvation counter=0, `mdu_ready`=1, `pipe_stall_out`=0, `pending_mask_out`=0.
- Reset mid-operation: queued entries are discarded. While reset is high, `mdu_ready` is low and handshakes are ignored.
- Pipeline latency: result at cycle N → `write_en_out` high in cycle N+1. The register file commits at the edge ending N+1, so the value is readable in N+2.
- MDU latency: accepted at cycle N → earliest `write_en_out` in cycle N+2. There is no FIFO bypass.
- Worst-case head wait: STARVE_LIMIT cycles of stall-free blocking, then one forced stall cycle that pops the head.
- `write_en_out` is high for exactly one cycle per committed write.

## Test plan
- Reset, then `pipe_valid=1, pipe_rd=5, pipe_data=0xDEAD` in cycle 1 → cycle 2: `write_en_out=1, rd_out=5, data_write_out=0xDEAD`; cycle 3: `write_en_out=0`.
- `pipe_rd=0` with `pipe_valid=1` and FIFO empty → `write_en_out` stays 0; the pending mask stays 0.
- MDU offers rd=7 (0x11) in cycle 1 while the pipeline is idle → accepted; `pending_mask_out[7]=1` from cycle 2; write appears in cycle 3; mask bit clears in cycle 4.
- Fill the FIFO with rd=3 and rd=4 while `pipe_valid` is held high (nonzero rd) → `mdu_ready=0`; `pipe_stall_out` rises after 4 blocked cycles; the next cycle writes rd=3; the counter restarts for rd=4.
- Pipeline write of rd=9 in the same cycle as an MDU accept of rd=9 → pipeline write first, MDU write afterwards; `pending_mask_out[9]` stays high throughout.
- Assert reset with FIFO count=2 → next cycle: count=0, `mdu_ready=1`, mask=0, `write_en_out=0`, and no queued write ever appears.

Source files
------------

// File: rtl/reg_writeback_arb.sv
// Writeback arbiter in front of the register file write port: merges the
// single-cycle pipeline result with buffered MDU results and exports a pending mask.
module reg_writeback_arb #(
  parameter int REG_DATA_WIDTH_POW = 6,
  parameter int REG_MEM_DEPTH_POW  = 5,
  parameter int FIFO_DEPTH         = 2,
  parameter int STARVE_LIMIT       = 4
) (
  input  logic                                clk_in,
  input  logic                                reset,
  input  logic                                pipe_valid,
  input  logic [REG_MEM_DEPTH_POW-1:0]        pipe_rd,
  input  logic [(1<<REG_DATA_WIDTH_POW)-1:0]  pipe_data,
  input  logic                                mdu_valid,
  input  logic [REG_MEM_DEPTH_POW-1:0]        mdu_rd,
  input  logic [(1<<REG_DATA_WIDTH_POW)-1:0]  mdu_data,
  output logic                                mdu_ready,
  output logic                                pipe_stall_out,
  output logic [REG_MEM_DEPTH_POW-1:0]        rd_out,
  output logic [(1<<REG_DATA_WIDTH_POW)-1:0]  data_write_out,
  output logic                                write_en_out,
  output logic [(1<<REG_MEM_DEPTH_POW)-1:0]   pending_mask_out
);
  localparam int DW = 1 << REG_DATA_WIDTH_POW;
  localparam int AW = REG_MEM_DEPTH_POW;
  localparam int NREG = 1 << REG_MEM_DEPTH_POW;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // MDU handshake: a result transfers on a rising edge where mdu_valid && mdu_ready;
  // mdu_ready depends only on registered occupancy (and reset), never on mdu_valid.
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [FIFO_DEPTH-1:0] slot_vld_q, slot_vld_d;
  logic [AW-1:0]   slot_rd_q   [FIFO_DEPTH];
  logic [AW-1:0]   slot_rd_d   [FIFO_DEPTH];
  logic [DW-1:0]   slot_data_q [FIFO_DEPTH];
  logic [DW-1:0]   slot_data_d [FIFO_DEPTH];
  logic            wen_q, wen_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            fifo_ne, pipe_live, push, pop;
  logic [NREG-1:0] mask;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    fifo_ne        = (count_q != '0);
    pipe_stall_out = (starve_q >= SW'(STARVE_LIMIT));
    mdu_ready      = !reset && (count_q < CW'(FIFO_DEPTH));
    push           = mdu_valid && mdu_ready && (mdu_rd != '0);
    pipe_live      = pipe_valid && (pipe_rd != '0);
    // A forced stall always drains the head; otherwise the head fills idle slots.
    pop            = fifo_ne && (pipe_stall_out || !pipe_live);
  end

  always_comb begin
    wen_d   = 1'b0;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    if (pop) begin
      wen_d   = 1'b1;
      rd_d    = slot_rd_q[head_q];
      wdata_d = slot_data_q[head_q];
    end else if (pipe_live) begin
      wen_d   = 1'b1;
      rd_d    = pipe_rd;
      wdata_d = pipe_data;
    end
  end

  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_rd_d   = slot_rd_q;
    slot_data_d = slot_data_q;
    head_d      = head_q;
    tail_d      = tail_q;
    if (pop) begin
      slot_vld_d[head_q] = 1'b0;
      head_d             = ptr_inc(head_q);
    end
    if (push) begin
      slot_vld_d[tail_q]  = 1'b1;
      slot_rd_d[tail_q]   = mdu_rd;
      slot_data_d[tail_q] = mdu_data;
      tail_d              = ptr_inc(tail_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    starve_d = starve_q;
    if (!fifo_ne || pop) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (slot_vld_q[i]) mask[slot_rd_q[i]] = 1'b1;
    end
    if (wen_q) mask[rd_q] = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      starve_q   <= '0;
      slot_vld_q <= '0;
      wen_q      <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      starve_q   <= starve_d;
      slot_vld_q <= slot_vld_d;
      wen_q      <= wen_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
    end
  end

  // Payload storage needs no reset; slot_vld_q qualifies every use.
  always_ff @(posedge clk_in) begin
    slot_rd_q   <= slot_rd_d;
    slot_data_q <= slot_data_d;
  end

  assign write_en_out     = wen_q;
  assign rd_out           = rd_q;
  assign data_write_out   = wdata_q;
  assign pending_mask_out = mask;
endmodule

// File: tb/tb_reg_writeback_arb.sv
// Directed bench for reg_writeback_arb: hand-computed vectors plus a scoreboard
// of expected register-file writes checked on every write_en_out pulse.
module tb_reg_writeback_arb;
  logic        clk_in = 1'b0;
  logic        reset;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [63:0] pipe_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [63:0] mdu_data;
  logic        mdu_ready;
  logic        pipe_stall_out;
  logic [4:0]  rd_out;
  logic [63:0] data_write_out;
  logic        write_en_out;
  logic [31:0] pending_mask_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [68:0] exp_q[$];
  logic [63:0] pdata_ctr = 64'hA000;

  reg_writeback_arb dut (
    .clk_in(clk_in), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready), .pipe_stall_out(pipe_stall_out),
    .rd_out(rd_out), .data_write_out(data_write_out),
    .write_en_out(write_en_out), .pending_mask_out(pending_mask_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write pulse must match the oldest expected write
  always @(negedge clk_in) begin
    if (write_en_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {59'd0, rd_out}, 64'd0);
      end else begin
        logic [68:0] e;
        e = exp_q.pop_front();
        check("sb_rd", {59'd0, rd_out}, {59'd0, e[68:64]});
        check("sb_data", data_write_out, e[63:0]);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    mdu_valid  = 1'b0; mdu_rd  = '0; mdu_data  = '0;
  endtask

  task automatic drive_pipe(input logic [4:0] rd, input logic [63:0] data);
    pipe_valid = 1'b1; pipe_rd = rd; pipe_data = data;
    if (rd != 5'd0) exp_q.push_back({rd, data});
  endtask

  task automatic drive_mdu(input logic [4:0] rd, input logic [63:0] data);
    mdu_valid = 1'b1; mdu_rd = rd; mdu_data = data;
  endtask

  // keeps the pipeline busy on rd 10 for n cycles while stall must stay low,
  // then expects the forced stall cycle that pops the head
  task automatic blocked_run(input int n, input logic [4:0] head_rd,
                             input logic [63:0] head_data);
    for (int i = 0; i < n; i++) begin
      check("stall_low", {63'd0, pipe_stall_out}, 64'd0);
      pdata_ctr = pdata_ctr + 1;
      drive_pipe(5'd10, pdata_ctr);
      step();
    end
    check("stall_high", {63'd0, pipe_stall_out}, 64'd1);
    pipe_valid = 1'b0;
    exp_q.push_back({head_rd, head_data});
    step();
    check("forced_pop_we", {63'd0, write_en_out}, 64'd1);
    check("forced_pop_rd", {59'd0, rd_out}, {59'd0, head_rd});
    check("stall_cleared", {63'd0, pipe_stall_out}, 64'd0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    check("rst_we", {63'd0, write_en_out}, 64'd0);
    check("rst_rd", {59'd0, rd_out}, 64'd0);
    check("rst_data", data_write_out, 64'd0);
    check("rst_mask", {32'd0, pending_mask_out}, 64'd0);
    check("rst_stall", {63'd0, pipe_stall_out}, 64'd0);
    check("rst_ready_in_reset", {63'd0, mdu_ready}, 64'd0);
    reset = 1'b0;
    #1;
    check("rst_ready_after", {63'd0, mdu_ready}, 64'd1);

    // pipeline write rd 5
    drive_pipe(5'd5, 64'hDEAD);
    step();
    idle();
    check("pipe_we", {63'd0, write_en_out}, 64'd1);
    check("pipe_rd", {59'd0, rd_out}, 64'd5);
    check("pipe_data", data_write_out, 64'hDEAD);
    check("pipe_mask", {32'd0, pending_mask_out}, 64'h20);
    step();
    check("pipe_we_drop", {63'd0, write_en_out}, 64'd0);
    check("pipe_rd_hold", {59'd0, rd_out}, 64'd5);
    check("pipe_mask_clr", {32'd0, pending_mask_out}, 64'd0);

    // pipeline write to x0 is a no-op
    drive_pipe(5'd0, 64'h1234);
    step();
    idle();
    check("x0_we", {63'd0, write_en_out}, 64'd0);
    check("x0_mask", {32'd0, pending_mask_out}, 64'd0);
    check("x0_data_hold", data_write_out, 64'hDEAD);

    // MDU result rd 7 with idle pipeline
    check("mdu_ready_empty", {63'd0, mdu_ready}, 64'd1);
    drive_mdu(5'd7, 64'h11);
    exp_q.push_back({5'd7, 64'h11});
    step();
    idle();
    check("mdu_c2_we", {63'd0, write_en_out}, 64'd0);
    check("mdu_c2_mask", {32'd0, pending_mask_out}, 64'h80);
    step();
    check("mdu_c3_we", {63'd0, write_en_out}, 64'd1);
    check("mdu_c3_rd", {59'd0, rd_out}, 64'd7);
    check("mdu_c3_mask", {32'd0, pending_mask_out}, 64'h80);
    step();
    check("mdu_c4_we", {63'd0, write_en_out}, 64'd0);
    check("mdu_c4_mask", {32'd0, pending_mask_out}, 64'd0);

    // MDU result to x0 is accepted and dropped
    drive_mdu(5'd0, 64'h77);
    step();
    idle();
    check("mdu_x0_mask", {32'd0, pending_mask_out}, 64'd0);
    check("mdu_x0_ready", {63'd0, mdu_ready}, 64'd1);
    step();
    check("mdu_x0_we", {63'd0, write_en_out}, 64'd0);

    // fill FIFO with rd 3 and rd 4 while the pipeline stays busy
    drive_pipe(5'd10, 64'hA0);
    drive_mdu(5'd3, 64'h33);
    step();
    check("fill_ready_1", {63'd0, mdu_ready}, 64'd1);
    drive_pipe(5'd10, 64'hA1);
    drive_mdu(5'd4, 64'h44);
    step();
    mdu_valid = 1'b0;
    check("fill_ready_full", {63'd0, mdu_ready}, 64'd0);
    check("fill_mask", {32'd0, pending_mask_out}, 64'h418);
    blocked_run(3, 5'd3, 64'h33);
    check("fill_ready_after_pop", {63'd0, mdu_ready}, 64'd1);
    blocked_run(4, 5'd4, 64'h44);
    idle();
    step();
    check("fill_drain_mask", {32'd0, pending_mask_out}, 64'd0);

    // pipeline and MDU target rd 9 in the same cycle
    drive_pipe(5'd9, 64'h900);
    drive_mdu(5'd9, 64'h901);
    exp_q.push_back({5'd9, 64'h901});
    step();
    idle();
    check("waw_first_data", data_write_out, 64'h900);
    check("waw_mask_a", {63'd0, pending_mask_out[9]}, 64'd1);
    step();
    check("waw_second_data", data_write_out, 64'h901);
    check("waw_mask_b", {63'd0, pending_mask_out[9]}, 64'd1);
    step();
    check("waw_mask_clr", {32'd0, pending_mask_out}, 64'd0);

    // reset with two queued entries discards them
    drive_pipe(5'd11, 64'hB0);
    drive_mdu(5'd12, 64'hC0);
    step();
    drive_pipe(5'd11, 64'hB1);
    drive_mdu(5'd13, 64'hC1);
    step();
    idle();
    check("prerst_full", {63'd0, mdu_ready}, 64'd0);
    check("prerst_mask", {32'd0, pending_mask_out}, 64'h3800);
    reset = 1'b1;
    drive_mdu(5'd14, 64'hE0);
    #1;
    check("midrst_ready", {63'd0, mdu_ready}, 64'd0);
    step();
    idle();
    reset = 1'b0;
    #1;
    check("postrst_we", {63'd0, write_en_out}, 64'd0);
    check("postrst_mask", {32'd0, pending_mask_out}, 64'd0);
    check("postrst_ready", {63'd0, mdu_ready}, 64'd1);
    check("postrst_rd", {59'd0, rd_out}, 64'd0);
    for (int i = 0; i < 6; i++) step();
    check("postrst_mask_late", {32'd0, pending_mask_out}, 64'd0);
    check("sb_drained", exp_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
